// File: rtl/parallel_lfsr_pkg.sv
// Shared types and constants for the parallel LFSR controller.
//   NIBBLE_W          : width of one LFSR step
//   lfsr_ctrl_state_e : controller FSM state
package parallel_lfsr_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    GATHER,
    DELIVER
  } lfsr_ctrl_state_e;

endpackage

// File: rtl/parallel_lfsr_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
//   i_req     : request vector
//   i_ptr     : index with highest priority this round
//   o_gnt     : one-hot grant (all zero when no request)
//   o_gnt_idx : binary index of the grant (0 when no request)
module rr_arbiter #(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_gnt_idx
);

  logic            w_found;
  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IdxW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_idx]   = 1'b1;
        o_gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/parallel_lfsr_ctrl.sv
// Shares one nibble-wide LFSR among N_REQ requesters. Reseeds on command, gathers
// WORD_W/4 nibbles (first nibble ends in the MSBs) and returns the packed word to
// the round-robin winner.
//   i_clk, i_reset_n            : clock, synchronous active-low reset
//   i_req / i_rsp_ready         : per-requester request level / response accept
//   o_rsp_valid / o_rsp_data    : one-hot response valid / shared response word
//   i_reseed_valid/_seed        : reseed command and seed; o_reseed_ack pulses on apply
//   o_lfsr_load / o_lfsr_seed   : seed load pulse and seed towards the LFSR
//   o_lfsr_req / i_lfsr_ready / i_lfsr_data : nibble handshake with the LFSR
//   o_busy                      : controller not idle
module parallel_lfsr_ctrl
  import parallel_lfsr_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LFSR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_rsp_ready,
  output logic [N_REQ-1:0]    o_rsp_valid,
  output logic [WORD_W-1:0]   o_rsp_data,
  input  logic                i_reseed_valid,
  input  logic [LFSR_W-1:0]   i_reseed_seed,
  output logic                o_reseed_ack,
  output logic                o_lfsr_load,
  output logic [LFSR_W-1:0]   o_lfsr_seed,
  output logic                o_lfsr_req,
  input  logic                i_lfsr_ready,
  input  logic [NIBBLE_W-1:0] i_lfsr_data,
  output logic                o_busy
);

  localparam int unsigned IDX_W        = $clog2(N_REQ);
  localparam int unsigned NIB_PER_WORD = WORD_W / NIBBLE_W;
  localparam int unsigned CNT_W        = $clog2(NIB_PER_WORD + 1);

  if ((WORD_W % NIBBLE_W) != 0 || WORD_W < NIBBLE_W) begin : g_bad_word_w
    $error("WORD_W must be a non-zero multiple of 4");
  end
  if (N_REQ < 2) begin : g_bad_n_req
    $error("N_REQ must be at least 2");
  end

  lfsr_ctrl_state_e  r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_winner;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [LFSR_W-1:0] r_seed;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic              r_reseed_ack;
  logic              r_lfsr_req;
  logic              r_busy;

  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Every output is a register set alongside the state, so there is no input->output path.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_winner     <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_seed       <= '0;
      r_rsp_valid  <= '0;
      r_reseed_ack <= 1'b0;
      r_lfsr_req   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_reseed_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Reseed has priority over pending requests.
          if (i_reseed_valid) begin
            r_state      <= SEED;
            r_seed       <= i_reseed_seed;
            r_reseed_ack <= 1'b1;
            r_busy       <= 1'b1;
          end else if (|w_gnt) begin
            r_state    <= GATHER;
            r_winner   <= w_gnt_idx;
            r_cnt      <= '0;
            r_lfsr_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        SEED: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        GATHER: begin
          if (i_lfsr_ready) begin
            r_word <= (r_word << NIBBLE_W) | WORD_W'(i_lfsr_data);
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(NIB_PER_WORD - 1)) begin
              r_state     <= DELIVER;
              r_lfsr_req  <= 1'b0;
              r_rsp_valid <= N_REQ'(1) << r_winner;
            end
          end
        end
        DELIVER: begin
          // Only the winner's accept matters; the word is held until then.
          if (i_rsp_ready[r_winner]) begin
            r_state     <= IDLE;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_ptr       <= (r_winner == IDX_W'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load pulse and ack coincide: both mark the single SEED cycle.
  assign o_lfsr_load  = r_reseed_ack;
  assign o_reseed_ack = r_reseed_ack;
  assign o_lfsr_seed  = r_seed;
  assign o_lfsr_req   = r_lfsr_req;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_word;
  assign o_busy       = r_busy;

endmodule
